// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared widths, phase and requester encodings for mem_arbiter
//
// Contents:
//   MEM_ADDR_W / MEM_DATA_W  default memory address and byte widths
//   phase_e                  LOAD (boot loader owns memory) / RUN (CPU + video)
//   req_id_e                 identifies which requester owns the memory port
package mem_pkg;

  localparam int MEM_ADDR_W = 12;
  localparam int MEM_DATA_W = 8;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } phase_e;

  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_LD   = 2'd1,
    REQ_CPU  = 2'd2,
    REQ_VID  = 2'd3
  } req_id_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - port bundle between the arbiter and its single-port memory
//
// Signals:
//   mem_addr   byte address presented to the memory
//   mem_we     write strobe, one cycle per accepted write
//   mem_wdata  write byte
//   mem_rdata  read byte, valid one cycle after the address was presented
// Modports:
//   master  arbiter side (drives address/control, samples read data)
//   slave   memory side
interface mem_arbiter_if
  import mem_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
) ();

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_addr,
    output mem_we,
    output mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr,
    input  mem_we,
    input  mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/arb2.sv
// rtl/arb2.sv - two-way CPU/video chooser used by mem_arbiter in RUN phase
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   req_cpu, req_vid  requests, already qualified by the caller's phase
//   cpu_lock          CPU asks to keep the port for the next byte of an opcode
//   gnt_cpu, gnt_vid  combinational, one-hot-or-zero grants
//
// Build option MEM_ARB_RR_EN: round-robin on conflicts (pointer starts
// CPU-favoured). Without it, fixed priority CPU over video and no state.
module arb2 (
  input  logic clk,
  input  logic rst_n,
  input  logic req_cpu,
  input  logic req_vid,
  input  logic cpu_lock,
  output logic gnt_cpu,
  output logic gnt_vid
);

`ifdef MEM_ARB_RR_EN

  logic vid_turn_q, vid_turn_d;  // 1: video wins the next conflict
  logic cpu_last_q, cpu_last_d;  // CPU owned the port last cycle
  logic conflict;
  logic lock_hold;

  always_comb begin
    conflict   = req_cpu & req_vid;
    // A locked fetch keeps the port only if the CPU already owns it, so the
    // lock cannot be used to jump ahead of video on the first byte.
    lock_hold  = cpu_lock & req_cpu & cpu_last_q;
    gnt_cpu    = req_cpu & (~req_vid | lock_hold | ~vid_turn_q);
    gnt_vid    = req_vid & ~gnt_cpu;
    // Uncontested grants leave the pointer alone; a locked conflict grant
    // counts as a CPU win so video is next once the lock drops.
    vid_turn_d = conflict ? gnt_cpu : vid_turn_q;
    cpu_last_d = gnt_cpu;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vid_turn_q <= 1'b0;
      cpu_last_q <= 1'b0;
    end else begin
      vid_turn_q <= vid_turn_d;
      cpu_last_q <= cpu_last_d;
    end
  end

`else

  // Fixed priority already keeps the CPU through a locked fetch, so the
  // lock and the clock are not needed here.
  logic unused_fixed;
  assign unused_fixed = &{1'b0, clk, rst_n, cpu_lock};

  always_comb begin
    gnt_cpu = req_cpu;
    gnt_vid = req_vid & ~req_cpu;
  end

`endif

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - boot-loader / CPU / video arbiter for one single-port memory
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   load_done                       pulse ending the boot-load phase
//   ld_req/ld_addr/ld_wdata         loader writes (LOAD phase only)
//   cpu_req/cpu_we/cpu_lock/
//   cpu_addr/cpu_wdata              CPU reads/writes (RUN phase)
//   vid_req/vid_addr                video reads (RUN phase)
//   ld_gnt/cpu_gnt/vid_gnt          request accepted this cycle (combinational)
//   cpu_rvalid/vid_rvalid           read data for that requester on rdata
//   rdata                           shared read data (memory output)
//   phase                           0 = LOAD, 1 = RUN
//   mem                             memory port bundle (master side)
//
// Build option MEM_ARB_RR_EN selects round-robin CPU/video arbitration
// (see arb2); default is fixed priority CPU over video.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_done,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic              cpu_lock,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              ld_gnt,
  output logic              cpu_gnt,
  output logic              vid_gnt,
  output logic              cpu_rvalid,
  output logic              vid_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              phase,
  mem_arbiter_if.master     mem
);

  localparam logic [0:0] ST_LOAD = LOAD;
  localparam logic [0:0] ST_RUN  = RUN;

  logic [0:0]        state_q, state_d;
  logic              cpu_rvalid_q, cpu_rvalid_d;
  logic              vid_rvalid_q, vid_rvalid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              mem_we_c;

  logic              in_load;
  logic              in_run;
  logic              arb_cpu_req;
  logic              arb_vid_req;
  logic              arb_cpu_gnt;
  logic              arb_vid_gnt;
  req_id_e           winner;

  // Grants are combinational, so they are also qualified by rst_n: nothing
  // may be accepted while reset is held, whatever the requesters drive.
  assign in_load     = rst_n & (state_q == ST_LOAD);
  assign in_run      = rst_n & (state_q == ST_RUN);
  assign arb_cpu_req = cpu_req & in_run;
  assign arb_vid_req = vid_req & in_run;

  arb2 u_arb2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_cpu  (arb_cpu_req),
    .req_vid  (arb_vid_req),
    .cpu_lock (cpu_lock),
    .gnt_cpu  (arb_cpu_gnt),
    .gnt_vid  (arb_vid_gnt)
  );

  always_comb begin
    winner = REQ_NONE;
    if (in_load && ld_req) begin
      winner = REQ_LD;
    end else if (arb_cpu_gnt) begin
      winner = REQ_CPU;
    end else if (arb_vid_gnt) begin
      winner = REQ_VID;
    end
  end

  // Memory port follows the winner in the same cycle; with no winner the
  // address and write data hold their last driven values.
  always_comb begin
    ld_gnt   = (winner == REQ_LD);
    cpu_gnt  = (winner == REQ_CPU);
    vid_gnt  = (winner == REQ_VID);
    mem_we_c = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    case (winner)
      REQ_LD: begin
        addr_d   = ld_addr;
        wdata_d  = ld_wdata;
        mem_we_c = 1'b1;
      end
      REQ_CPU: begin
        addr_d   = cpu_addr;
        wdata_d  = cpu_wdata;
        mem_we_c = cpu_we;
      end
      REQ_VID: begin
        addr_d   = vid_addr;
      end
      default: begin
      end
    endcase
  end

  // The memory has one cycle of read latency, so rvalid is the read grant
  // delayed by one cycle.
  always_comb begin
    cpu_rvalid_d = cpu_gnt & ~cpu_we;
    vid_rvalid_d = vid_gnt;
  end

  // LOAD -> RUN on load_done; a loader write in that same cycle has already
  // been granted above while still in LOAD. RUN is left only through reset.
  always_comb begin
    state_d = state_q;
    if ((state_q == ST_LOAD) && load_done) begin
      state_d = ST_RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_LOAD;
      cpu_rvalid_q <= 1'b0;
      vid_rvalid_q <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      vid_rvalid_q <= vid_rvalid_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

  assign mem.mem_addr  = addr_d;
  assign mem.mem_we    = mem_we_c;
  assign mem.mem_wdata = wdata_d;

  assign rdata      = mem.mem_rdata;
  assign cpu_rvalid = cpu_rvalid_q;
  assign vid_rvalid = vid_rvalid_q;
  assign phase      = state_q[0];

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with a behavioural model
module tb_mem_arbiter;
  import mem_pkg::*;

  localparam int AW    = 12;
  localparam int DW    = 8;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load_done = 1'b0;
  logic          ld_req = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [DW-1:0] ld_wdata = '0;
  logic          cpu_req = 1'b0;
  logic          cpu_we = 1'b0;
  logic          cpu_lock = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          vid_req = 1'b0;
  logic [AW-1:0] vid_addr = '0;
  logic          ld_gnt, cpu_gnt, vid_gnt, cpu_rvalid, vid_rvalid, phase;
  logic [DW-1:0] rdata;

  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) mem_bus ();

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_done  (load_done),
    .ld_req     (ld_req),
    .ld_addr    (ld_addr),
    .ld_wdata   (ld_wdata),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_lock   (cpu_lock),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .vid_req    (vid_req),
    .vid_addr   (vid_addr),
    .ld_gnt     (ld_gnt),
    .cpu_gnt    (cpu_gnt),
    .vid_gnt    (vid_gnt),
    .cpu_rvalid (cpu_rvalid),
    .vid_rvalid (vid_rvalid),
    .rdata      (rdata),
    .phase      (phase),
    .mem        (mem_bus)
  );

  // Single-port synchronous memory, one cycle read latency.
  logic [DW-1:0] phys_mem [DEPTH];
  always @(posedge clk) begin
    if (mem_bus.mem_we) phys_mem[mem_bus.mem_addr] <= mem_bus.mem_wdata;
    mem_bus.mem_rdata <= phys_mem[mem_bus.mem_addr];
  end

  typedef struct {
    req_id_e       who;
    logic [DW-1:0] data;
    bit            known;
    int            due;
  } rd_exp_t;

  rd_exp_t       exp_q[$];
  rd_exp_t       mon_e;
  logic [DW-1:0] ref_mem [DEPTH];
  bit            written [DEPTH];
  bit            m_run;
  bit            m_cpu_last;
`ifdef MEM_ARB_RR_EN
  bit            m_vid_turn;
`endif
  logic [AW-1:0] m_addr;
  bit            g_cpu, g_vid;
  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;
  logic [DW-1:0] boot [4] = '{8'hA2, 8'h2A, 8'h60, 8'h0C};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_bit(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %b, want %b (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic chk_val(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [AW-1:0] rand_addr();
    return 12'h1F0 + 12'($urandom_range(0, 31));
  endfunction

  // One bus cycle. Entered just after a rising edge with inputs applied;
  // the model decides who must win from the arbitration rules, checks the
  // DUT at the falling edge, and queues read results for the monitor.
  task automatic run_cycle();
    bit            e_ld, e_cpu, e_vid, e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    @(negedge clk);
    e_ld  = 1'b0;
    e_cpu = 1'b0;
    e_vid = 1'b0;
    if (!m_run) begin
      e_ld = ld_req;
    end else if (cpu_req && vid_req) begin
      if (cpu_lock && m_cpu_last) e_cpu = 1'b1;
`ifdef MEM_ARB_RR_EN
      else if (m_vid_turn) e_vid = 1'b1;
`endif
      else e_cpu = 1'b1;
`ifdef MEM_ARB_RR_EN
      m_vid_turn = e_cpu;
`endif
    end else begin
      e_cpu = cpu_req;
      e_vid = vid_req;
    end
    e_we    = e_ld | (e_cpu & cpu_we);
    e_addr  = e_ld ? ld_addr : e_cpu ? cpu_addr : e_vid ? vid_addr : m_addr;
    e_wdata = e_ld ? ld_wdata : cpu_wdata;

    chk_bit("phase", phase, m_run);
    chk_bit("ld_gnt", ld_gnt, e_ld);
    chk_bit("cpu_gnt", cpu_gnt, e_cpu);
    chk_bit("vid_gnt", vid_gnt, e_vid);
    chk_bit("mem_we", mem_bus.mem_we, e_we);
    chk_val("mem_addr", 32'(mem_bus.mem_addr), 32'(e_addr));
    if (e_we) chk_val("mem_wdata", 32'(mem_bus.mem_wdata), 32'(e_wdata));

    if (e_cpu && !cpu_we)
      exp_q.push_back('{who: REQ_CPU, data: ref_mem[cpu_addr], known: written[cpu_addr], due: cyc + 1});
    if (e_vid)
      exp_q.push_back('{who: REQ_VID, data: ref_mem[vid_addr], known: written[vid_addr], due: cyc + 1});
    if (e_we) begin
      ref_mem[e_addr] = e_wdata;
      written[e_addr] = 1'b1;
    end
    m_addr     = e_addr;
    m_cpu_last = e_cpu;
    if (!m_run && load_done) m_run = 1'b1;
    g_cpu = e_cpu;
    g_vid = e_vid;
    @(posedge clk);
    #1;
  endtask

  // Asserts reset with every requester active and checks the cleared state.
  task automatic apply_reset(input int n);
    rst_n    = 1'b0;
    ld_req   = 1'b1;
    cpu_req  = 1'b1;
    vid_req  = 1'b1;
    cpu_we   = 1'b1;
    exp_q.delete();
    m_run      = 1'b0;
    m_cpu_last = 1'b0;
`ifdef MEM_ARB_RR_EN
    m_vid_turn = 1'b0;
`endif
    m_addr     = '0;
    g_cpu      = 1'b0;
    g_vid      = 1'b0;
    repeat (n) begin
      @(negedge clk);
      chk_bit("rst_phase", phase, 1'b0);
      chk_bit("rst_ld_gnt", ld_gnt, 1'b0);
      chk_bit("rst_cpu_gnt", cpu_gnt, 1'b0);
      chk_bit("rst_vid_gnt", vid_gnt, 1'b0);
      chk_bit("rst_cpu_rvalid", cpu_rvalid, 1'b0);
      chk_bit("rst_vid_rvalid", vid_rvalid, 1'b0);
      chk_bit("rst_mem_we", mem_bus.mem_we, 1'b0);
      chk_val("rst_mem_addr", 32'(mem_bus.mem_addr), 32'h0);
      chk_val("rst_mem_wdata", 32'(mem_bus.mem_wdata), 32'h0);
    end
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    ld_req    = 1'b0;
    cpu_req   = 1'b0;
    vid_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_lock  = 1'b0;
    load_done = 1'b0;
  endtask

  // Read-data monitor: every cycle either a queued read is due (right
  // requester flagged, right byte) or both rvalids must be low.
  always @(negedge clk) begin
    if (rst_n) begin
      if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
        mon_e = exp_q.pop_front();
        chk_bit("cpu_rvalid", cpu_rvalid, mon_e.who == REQ_CPU);
        chk_bit("vid_rvalid", vid_rvalid, mon_e.who == REQ_VID);
        if (mon_e.known) chk_val("rdata", 32'(rdata), 32'(mon_e.data));
      end else begin
        chk_bit("cpu_rvalid_idle", cpu_rvalid, 1'b0);
        chk_bit("vid_rvalid_idle", vid_rvalid, 1'b0);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    apply_reset(3);

    // Boot load of the opcode bytes while CPU and video knock on the door.
    for (int i = 0; i < 4; i++) begin
      ld_req   = 1'b1;
      ld_addr  = 12'h200 + 12'(i);
      ld_wdata = boot[i];
      cpu_req  = 1'b1;
      cpu_we   = 1'b0;
      cpu_addr = 12'h200;
      vid_req  = 1'b1;
      vid_addr = 12'h201;
      run_cycle();
    end
    cpu_req = 1'b0;
    vid_req = 1'b0;
    for (int i = 0; i < 12; i++) begin
      ld_req   = 1'($urandom_range(0, 1));
      ld_addr  = 12'h1F0 + 12'($urandom_range(0, 15));
      ld_wdata = 8'($urandom);
      run_cycle();
    end

    // load_done together with a loader write.
    ld_req    = 1'b1;
    ld_addr   = 12'h1FF;
    ld_wdata  = 8'h5A;
    load_done = 1'b1;
    run_cycle();

    // RUN: loader ignored, CPU read of the first boot byte.
    load_done = 1'b0;
    ld_addr   = 12'h200;
    ld_wdata  = 8'hFF;
    cpu_req   = 1'b1;
    cpu_we    = 1'b0;
    cpu_addr  = 12'h200;
    run_cycle();
    cpu_req = 1'b0;
    ld_req  = 1'b0;
    run_cycle();

    // Continuous CPU and video reads.
    cpu_req  = 1'b1;
    vid_req  = 1'b1;
    cpu_addr = 12'h202;
    vid_addr = 12'h203;
    for (int i = 0; i < 8; i++) begin
      run_cycle();
      if (g_cpu) cpu_addr = 12'h200 + 12'($urandom_range(0, 3));
      if (g_vid) vid_addr = 12'h200 + 12'($urandom_range(0, 3));
    end
    cpu_req = 1'b0;
    vid_req = 1'b0;
    run_cycle();

    // Locked two-byte opcode fetch against a busy video requester.
    cpu_lock = 1'b1;
    cpu_req  = 1'b1;
    cpu_addr = 12'h200;
    vid_req  = 1'b1;
    vid_addr = 12'h1F0;
    for (int k = 0; k < 3 && !g_cpu; k++) run_cycle();
    cpu_addr = 12'h201;
    run_cycle();
    cpu_lock = 1'b0;
    cpu_req  = 1'b0;
    run_cycle();
    vid_req = 1'b0;
    run_cycle();

    // Random RUN traffic; requesters hold their fields until granted.
    for (int i = 0; i < 400; i++) begin
      if (!cpu_req || g_cpu) begin
        cpu_req   = ($urandom_range(0, 9) < 6);
        cpu_we    = ($urandom_range(0, 3) == 0);
        cpu_lock  = ($urandom_range(0, 2) == 0);
        cpu_addr  = rand_addr();
        cpu_wdata = 8'($urandom);
      end
      if (!vid_req || g_vid) begin
        vid_req  = 1'($urandom_range(0, 1));
        vid_addr = rand_addr();
      end
      ld_req    = 1'($urandom_range(0, 1));
      ld_addr   = rand_addr();
      ld_wdata  = 8'($urandom);
      load_done = 1'($urandom_range(0, 1));
      run_cycle();
    end

    // Reset the cycle after a video read grant: the read must be dropped.
    cpu_req   = 1'b0;
    ld_req    = 1'b0;
    load_done = 1'b0;
    vid_req   = 1'b1;
    vid_addr  = 12'h201;
    run_cycle();
    apply_reset(2);
    repeat (3) run_cycle();

    // Second boot after reset still works end to end.
    ld_req    = 1'b1;
    ld_addr   = 12'h203;
    ld_wdata  = 8'h77;
    load_done = 1'b1;
    run_cycle();
    ld_req    = 1'b0;
    load_done = 1'b0;
    cpu_req   = 1'b1;
    cpu_we    = 1'b0;
    cpu_addr  = 12'h203;
    run_cycle();
    cpu_req = 1'b0;
    run_cycle();
    run_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, memory address width (4096 bytes).
REQ-002 SHALL have parameter DATA_W, default 8, memory byte width.
REQ-003 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port load_done  in  1  one-cycle pulse ending boot-load phase.
REQ-006 SHALL have ports ld_req/ld_addr/ld_wdata  in  1/ADDR_W/DATA_W  loader write request (write-only).
REQ-007 SHALL have ports cpu_req/cpu_we/cpu_lock/cpu_addr/cpu_wdata  in  1/1/1/ADDR_W/DATA_W  CPU request.
REQ-008 SHALL have ports vid_req/vid_addr  in  1/ADDR_W  video/sprite read request.
REQ-009 SHALL have ports ld_gnt, cpu_gnt, vid_gnt  out  1 each  request accepted this cycle.
REQ-010 SHALL have ports cpu_rvalid, vid_rvalid  out  1 each  read data valid for that requester.
REQ-011 SHALL have port rdata  out  DATA_W  shared read data, equals mem_rdata.
REQ-012 SHALL have ports mem_addr/mem_we/mem_wdata  out  ADDR_W/1/DATA_W, and mem_rdata  in  DATA_W: single-port synchronous memory, 1-cycle read latency.
REQ-013 SHALL have port phase  out  1  0=LOAD, 1=RUN.

Function
REQ-014 SHALL implement FSM states LOAD and RUN; LOAD after reset; LOAD->RUN on load_done; RUN exits only by reset.
REQ-015 In LOAD, SHALL grant only ld_req; cpu_gnt and vid_gnt stay 0.
REQ-016 In RUN, SHALL ignore ld_req (ld_gnt 0) and arbitrate cpu_req vs vid_req.
REQ-017 Grant SHALL be combinational in the request cycle; at most one gnt high per cycle; a single requester with req held gets gnt every cycle.
REQ-018 On grant, mem_addr/mem_we/mem_wdata SHALL drive the winner's fields the same cycle; mem_we=1 only for loader grant or cpu grant with cpu_we=1.
REQ-019 With no grant, mem_we SHALL be 0; mem_addr SHALL hold its last driven value.
REQ-020 Read grant in cycle N SHALL give that requester's rvalid high in cycle N+1 only, with rdata valid; writes never produce rvalid.
REQ-021 While cpu_lock=1 and the CPU held the previous grant, SHALL grant CPU over video regardless of arbitration (atomic 2-byte opcode fetch); lock released when cpu_lock=0 or cpu_req=0.
REQ-022 load_done arriving while ld_req is high SHALL complete that cycle's loader write and switch to RUN next cycle.
REQ-023 Requesters SHALL hold req and fields stable until gnt; arbiter need not latch unaccepted requests.

Reset
REQ-024 On rst_n low, SHALL asynchronously set phase=LOAD, all gnt=0, all rvalid=0, mem_we=0, mem_addr=0, mem_wdata=0, round-robin pointer=CPU-favoured.
REQ-025 Read in flight at reset SHALL be dropped; no rvalid after rst_n rises.

Configuration
REQ-026 With MEM_ARB_RR_EN defined, SHALL arbitrate CPU/video round-robin: on conflict grant the requester not granted last; pointer updates only on conflict grants.
REQ-027 Without MEM_ARB_RR_EN, SHALL use fixed priority CPU > video; no pointer state.

Structure
REQ-028 Package mem_pkg SHALL hold ADDR_W/DATA_W defaults, phase enum (LOAD, RUN) and requester-ID enum (REQ_LD, REQ_CPU, REQ_VID).
REQ-029 Sub-module arb2 SHALL implement the two-way CPU/video choice (round-robin or fixed per macro), instanced once.

Verification
REQ-030 Reset then ld_req with addr 0x200..0x203, data 0xA2,0x2A,0x60,0x0C -> ld_gnt each cycle, mem_we=1, bytes written; cpu_req concurrently never granted.
REQ-031 load_done, then cpu_req read 0x200 -> cpu_gnt cycle N, cpu_rvalid cycle N+1, rdata=0xA2.
REQ-032 RUN, cpu_req and vid_req continuous reads (RR_EN) -> grants alternate CPU,VID,CPU,VID; without macro -> CPU every cycle, vid_gnt 0.
REQ-033 cpu_lock=1 reads 0x200 then 0x201 with vid_req high -> consecutive cpu_gnt, rdata 0xA2 then 0x2A, vid granted after.
REQ-034 rst_n low the cycle after a vid read grant -> vid_rvalid stays 0, phase=LOAD, mem_we=0.
